// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: FSM encoding, port ids, default widths
// and the read-return tag carried through the read pipeline.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// Read-return tag pipeline: carries {valid, port} of each granted read for
// DEPTH cycles so the data coming out of dmem is steered to the right port.
module dmem_arb_rdpipe
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_port,
  output logic pop_valid,
  output logic pop_port
);

  rd_tag_t stage [DEPTH];

  // NOTE: every stage is reset, not just the valid bit, so a reset mid-flight
  // drops outstanding reads instead of letting them emerge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: push_valid, port: push_port};
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_valid = stage[DEPTH-1].valid;
  assign pop_port  = stage[DEPTH-1].port;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port dmem syncram: sticky ownership
// with a burst cap, fixed-latency read return. Define DMEM_ARB_WRITE_PROTECT_EN
// to block port 1 writes below PROT_LIMIT and report them on p1_err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = 'h100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_q,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_q,
`ifdef DMEM_ARB_WRITE_PROTECT_EN
  output logic              p1_err,
`endif
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  localparam logic [3:0] BURST_CAP = MAX_BURST[3:0];

  logic [1:0] state, state_nx;
  logic [3:0] burst_cnt, burst_nx;
  logic       gnt0, gnt1;
  logic       p1_blocked;
  logic       pop_valid, pop_port;

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      OWN0: begin
        if (p0_req && (!p1_req || burst_cnt < BURST_CAP)) gnt0 = 1'b1;
        else if (p1_req)                                   gnt1 = 1'b1;
      end
      OWN1: begin
        if (p1_req && (!p0_req || burst_cnt < BURST_CAP)) gnt1 = 1'b1;
        else if (p0_req)                                   gnt0 = 1'b1;
      end
      default: begin
        if (p0_req)      gnt0 = 1'b1;
        else if (p1_req) gnt1 = 1'b1;
      end
    endcase
    // Grants are combinational, so they must be masked while reset is held.
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_nx = IDLE;
    burst_nx = 4'd0;
    if (gnt0) begin
      state_nx = OWN0;
      burst_nx = (state == OWN0) ? burst_inc(burst_cnt) : 4'd1;
    end else if (gnt1) begin
      state_nx = OWN1;
      burst_nx = (state == OWN1) ? burst_inc(burst_cnt) : 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
    end
  end

`ifdef DMEM_ARB_WRITE_PROTECT_EN
  assign p1_blocked = p1_wren && (p1_addr < PROT_LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) p1_err <= 1'b0;
    else        p1_err <= gnt1 && p1_blocked;
  end
`else
  assign p1_blocked = 1'b0;
`endif

  always_comb begin
    dmem_address = '0;
    dmem_data    = '0;
    dmem_wren    = 1'b0;
    if (gnt0) begin
      dmem_address = p0_addr;
      dmem_data    = p0_data;
      dmem_wren    = p0_wren;
    end else if (gnt1) begin
      dmem_address = p1_addr;
      dmem_data    = p1_data;
      dmem_wren    = p1_wren && !p1_blocked;
    end
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  dmem_arb_rdpipe #(
    .DEPTH(RD_LAT)
  ) u_rdpipe (
    .clock     (clock),
    .reset     (reset),
    .push_valid((gnt0 && !p0_wren) || (gnt1 && !p1_wren)),
    .push_port (gnt1 ? PORT_AUX : PORT_CPU),
    .pop_valid (pop_valid),
    .pop_port  (pop_port)
  );

  assign p0_rvalid = pop_valid && (pop_port == PORT_CPU);
  assign p1_rvalid = pop_valid && (pop_port == PORT_AUX);

  // Read data is not muxed; rvalid alone tells each requester when to take it.
  assign p0_q = dmem_q;
  assign p1_q = dmem_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port dmem syncram between two requesters.
- Port 0 is the processor load/store path. Port 1 is a secondary master: a program/data loader or debug DMA.
- Sits between the requesters and dmem in the top-level wrapper, clocked by the dmem clock.
- Performs sticky arbitration with a burst cap and routes read data back with the fixed syncram read latency.

Parameters:
- ADDR_W, 12: dmem word-address width.
- DATA_W, 32: data width.
- RD_LAT, 1: cycles from the edge that captures a read address to valid dmem_q (1..3).
- MAX_BURST, 4: maximum consecutive grants to one port while the other port is requesting (1..15).
- PROT_LIMIT, 12'h100: port 1 write floor. Used only with the optional feature.

Ports:
- clock  in  1  dmem clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request, held until granted.
- p0_wren  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 address.
- p0_data  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_q  out  DATA_W  port 0 read data.
- p1_req, p1_wren, p1_addr, p1_data, p1_gnt, p1_rvalid, p1_q: same as port 0, for port 1.
- p1_err  out  1  port 1 write rejected. Present only with the optional feature.
- dmem_address  out  ADDR_W  to dmem.
- dmem_data  out  DATA_W  to dmem.
- dmem_wren  out  1  to dmem.
- dmem_q  in  DATA_W  from dmem.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE, burst_cnt=0, read pipeline cleared.
  - All gnt/rvalid/err outputs 0; dmem_wren 0; dmem_address 0; dmem_data 0.
  - Reset mid-operation drops in-flight reads; no rvalid is issued for them after release.
- Grant handshake:
  - gnt is combinational from req and the registered state.
  - A transfer occurs on the rising edge where req & gnt = 1.
  - Requesters keep addr/data/wren stable while req=1 and gnt=0.
  - At most one gnt is high per cycle.
- Address path: dmem_address/dmem_data/dmem_wren are muxed from the granted port. When nothing is granted, dmem_wren=0 and address/data hold 0.
- States:
  - IDLE:
    - Both requesting: port 0 wins (processor priority).
    - Only one requesting: that port wins.
    - Next state is OWN0 or OWN1 per the winner, with burst_cnt=1.
  - OWNx, x still requesting:
    - Grant x while the other port is idle, or while burst_cnt<MAX_BURST.
    - Increment burst_cnt, saturating.
  - OWNx, x requesting, other port requesting, burst_cnt==MAX_BURST:
    - Grant the other port and move to OWN(other) with burst_cnt=1.
  - OWNx, x not requesting:
    - Other port requesting: grant it, move to OWN(other), burst_cnt=1.
    - Neither requesting: go to IDLE, no grant.
- Read return:
  - A shift pipeline of depth RD_LAT carries {valid, port} for each granted read. Writes do not enter it.
  - pN_rvalid pulses for exactly one cycle, RD_LAT cycles after that read's grant edge.
  - p0_q and p1_q both pass dmem_q straight through; rvalid alone qualifies the data.
- Back-to-back reads: one per cycle is sustained; the return order equals the grant order.
- Simultaneous read-after-write to the same address by different ports: the order follows grant order. Dmem returns the old or new value per the syncram read-during-write setting; the arbiter does not forward data.

Optional Feature:
- Macro DMEM_ARB_WRITE_PROTECT_EN.
- When defined:
  - A granted port 1 write with p1_addr < PROT_LIMIT is still granted, but dmem_wren is forced to 0.
  - p1_err pulses high for one cycle, registered, the cycle after the grant.
  - Port 0 is never restricted.
- When undefined: no p1_err port; all port 1 writes reach dmem.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - port-id constants PORT_CPU=1'b0, PORT_AUX=1'b1;
  - default ADDR_W/DATA_W.
- One sub-module, dmem_arb_rdpipe: the RD_LAT-deep {valid, port} shift pipeline with asynchronous active-low clear.

Test Plan:
- Single read, RD_LAT=1: p0_req with read, p0_addr=12'h010 → p0_gnt=1 the same cycle; p0_rvalid=1 exactly 1 cycle after the grant edge, p0_q equals the dmem word at 0x010; p1_rvalid stays 0.
- Tie from IDLE: both ports request reads at once → p0 granted first, state OWN0; p1 granted the next cycle after p0 drops req.
- Burst cap, MAX_BURST=4: both ports hold req continuously → grant sequence p0,p0,p0,p0,p1,p1,p1,p1,p0…; never two gnts in one cycle.
- Write then read: p1 writes 32'hDEADBEEF to 0x200, then p0 reads 0x200 → p0_q=32'hDEADBEEF with p0_rvalid.
- Reset mid-read: assert reset=0 one cycle after a p1 read grant → p1_rvalid never pulses; all outputs 0 while reset is low; state returns to IDLE.
- With DMEM_ARB_WRITE_PROTECT_EN: p1 writes to 0x050 → dmem_wren=0 and p1_err pulses once; a later p1 read of 0x050 returns the unchanged value. The same write from p0 succeeds.
